// File: rtl/fault_pkg.sv
// ---------------------------------------------------------------------------
// fault_pkg
// Shared types and widths for the fault supervisor and its timer.
//   state_t   : encoded supervisor state, also exported as telemetry
//   STATE_W   : width of the encoded state
//   RETRY_W   : width of the auto-restart counter
//   TIMER_W   : width of the shared cooldown / good-time counter
//   eff_cool  : maps a zero cooldown length onto one cycle
// ---------------------------------------------------------------------------
package fault_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;
    localparam int TIMER_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_NORMAL   = 3'd0,
        ST_WARN     = 3'd1,
        ST_TRIP     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    // A zero-length cooldown would never produce a done flag, so treat it
    // as the shortest meaningful period.
    function automatic logic [TIMER_W-1:0] eff_cool(input logic [TIMER_W-1:0] c);
        return (c == '0) ? TIMER_W'(1) : c;
    endfunction

endpackage

// File: rtl/fs_timer.sv
// ---------------------------------------------------------------------------
// fs_timer
// Loadable down-counter shared by the cooldown period and the good-time
// (retry clear) period. Counts down to zero and holds there.
//   clk      : clock, posedge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   done     : high while the count is 1, i.e. the last cycle of a period
// ---------------------------------------------------------------------------
module fs_timer
    import fault_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    // Done marks the final cycle so the owner can leave its state on the
    // same edge the period expires.
    assign done = (count == TIMER_W'(1));

endmodule

// File: rtl/fault_supervisor.sv
// ---------------------------------------------------------------------------
// fault_supervisor
// Moore FSM supervising a power stage from debounced fault qualifiers.
// Escalates NORMAL -> WARN -> TRIP, auto-restarts through COOLDOWN a
// limited number of times, and latches LOCKOUT once the restart budget
// is spent. All outputs are registered alongside the state register.
//   clk       : clock, posedge
//   rst       : synchronous active-high reset
//   flt_hi    : fault-high qualifier
//   flt_pers  : persistent-fault qualifier (implies flt_hi)
//   flt_lo    : fault-low (recovered) qualifier; loses to flt_hi
//   clr_req   : operator clear, only acted on in LOCKOUT with flt_lo
//   warn      : fault seen, not yet persistent
//   derate    : reduced-power request
//   shutdown  : power stage disable
//   lockout   : latched fault awaiting clr_req
//   trip_evt  : one-cycle pulse on each entry to TRIP
//   retry_cnt : auto-restarts since the last clean period
//   state     : encoded FSM state for telemetry
// ---------------------------------------------------------------------------
module fault_supervisor
    import fault_pkg::*;
#(
    parameter logic [TIMER_W-1:0] COOL_CYCLES = 16'd2000,
    parameter logic [RETRY_W-1:0] MAX_RETRY   = 4'd3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flt_hi,
    input  logic               flt_pers,
    input  logic               flt_lo,
    input  logic               clr_req,
    output logic               warn,
    output logic               derate,
    output logic               shutdown,
    output logic               lockout,
    output logic               trip_evt,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
);

    state_t             state_q;
    state_t             state_d;
    logic [RETRY_W-1:0] retry_d;
    logic               fault_hi;
    logic               recovered;
    logic               tmr_load;
    logic               tmr_done;

    // flt_pers implies a high fault even if flt_hi were to glitch low, and
    // a simultaneous high/low qualifier is resolved in favour of the fault.
    assign fault_hi  = flt_hi | flt_pers;
    assign recovered = flt_lo & ~fault_hi;

    // One timer serves both periods: any state change reloads it, so it
    // starts a cooldown on COOLDOWN entry and a good-time run on NORMAL
    // entry. Other states simply ignore it.
    assign tmr_load = (state_d != state_q);

    fs_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (eff_cool(COOL_CYCLES)),
        .done     (tmr_done)
    );

    // Next-state and next-retry logic.
    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;

        case (state_q)
            ST_NORMAL: begin
                if (flt_pers) begin
                    state_d = ST_TRIP;
                end else if (fault_hi) begin
                    state_d = ST_WARN;
                end
            end

            ST_WARN: begin
                if (flt_pers) begin
                    state_d = ST_TRIP;
                end else if (recovered) begin
                    state_d = ST_NORMAL;
                end
            end

            ST_TRIP: begin
                if (recovered) begin
                    // The guard also keeps retry_cnt from ever passing
                    // MAX_RETRY, so no separate saturation is needed.
                    if (retry_cnt >= MAX_RETRY) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        retry_d = retry_cnt + RETRY_W'(1);
                        state_d = ST_COOLDOWN;
                    end
                end
            end

            ST_COOLDOWN: begin
                if (fault_hi) begin
                    state_d = ST_TRIP;
                end else if (tmr_done) begin
                    state_d = ST_NORMAL;
                end
            end

            ST_LOCKOUT: begin
                if (clr_req && recovered) begin
                    state_d = ST_NORMAL;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = ST_LOCKOUT;
            end
        endcase

        // A full clean good-time run in NORMAL forgives earlier restarts.
        // The final cycle only counts as clean if no fault arrives in it.
        if (state_q == ST_NORMAL && state_d == ST_NORMAL && tmr_done) begin
            retry_d = '0;
        end
    end

    // State and registered Moore outputs, decoded from the next state so
    // they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_NORMAL;
            retry_cnt <= '0;
            warn      <= 1'b0;
            derate    <= 1'b0;
            shutdown  <= 1'b0;
            lockout   <= 1'b0;
            trip_evt  <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_cnt <= retry_d;
            warn      <= (state_d == ST_WARN);
            derate    <= (state_d == ST_WARN);
            shutdown  <= (state_d == ST_TRIP) || (state_d == ST_COOLDOWN) ||
                         (state_d == ST_LOCKOUT);
            lockout   <= (state_d == ST_LOCKOUT);
            trip_evt  <= (state_d == ST_TRIP) && (state_q != ST_TRIP);
        end
    end

    assign state = state_q;

endmodule

// File: doc/fault_supervisor.md
FAULT_SUPERVISOR -- requirements
Module: fault_supervisor

Interface
REQ-001 Parameter: COOL_CYCLES, 16'd2000, cooldown after a trip before re-enable, and good-time needed to clear the retry count.
REQ-002 Parameter: MAX_RETRY, 4'd3, auto-restarts allowed before lockout.
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: flt_hi  input  1  debounced fault-high qualifier.
REQ-006 Port: flt_pers  input  1  persistent-fault qualifier (implies flt_hi).
REQ-007 Port: flt_lo  input  1  debounced fault-low (recovered) qualifier.
REQ-008 Port: clr_req  input  1  operator clear; single-cycle pulse; honoured only in LOCKOUT.
REQ-009 Port: warn  output  1  fault seen, not yet persistent.
REQ-010 Port: derate  output  1  reduced-power request.
REQ-011 Port: shutdown  output  1  power stage disable.
REQ-012 Port: lockout  output  1  latched fault, needs clr_req.
REQ-013 Port: trip_evt  output  1  one-cycle pulse on each entry to TRIP.
REQ-014 Port: retry_cnt  output  4  auto-restarts since the last clean period.
REQ-015 Port: state  output  3  encoded FSM state for telemetry.

Function
REQ-016 FSM states SHALL be NORMAL=0, WARN=1, TRIP=2, COOLDOWN=3, LOCKOUT=4; values 5-7 SHALL go to LOCKOUT on the next edge.
REQ-017 The FSM SHALL be Moore type; all outputs SHALL be registered and SHALL change on the same edge as the state register, which is one cycle after the qualifying input is sampled.
REQ-018 Output decode:
- NORMAL: all outputs 0.
- WARN: warn=1, derate=1.
- TRIP and COOLDOWN: shutdown=1.
- LOCKOUT: shutdown=1, lockout=1.
REQ-019 NORMAL transitions: flt_pers -> TRIP; else flt_hi -> WARN; flt_pers has priority.
REQ-020 WARN transitions: flt_pers -> TRIP; else flt_lo -> NORMAL; otherwise stay in WARN.
REQ-021 TRIP transitions: on flt_lo, retry_cnt==MAX_RETRY -> LOCKOUT; otherwise retry_cnt increments and the FSM enters COOLDOWN with the timer loaded to COOL_CYCLES.
REQ-022 COOLDOWN transitions: the timer decrements every cycle; flt_hi -> TRIP with no increment; timer==1 with flt_hi low -> NORMAL.
REQ-023 LOCKOUT transitions: clr_req with flt_lo -> NORMAL and retry_cnt=0; clr_req without flt_lo SHALL be ignored.
REQ-024 Retry clear: NORMAL held for COOL_CYCLES consecutive cycles SHALL clear retry_cnt; the good-time timer SHALL reload when NORMAL is left or re-entered.
REQ-025 trip_evt SHALL assert for one cycle on each transition into TRIP and never while remaining in TRIP.
REQ-026 retry_cnt SHALL saturate at MAX_RETRY and never wrap.
REQ-027 If flt_hi and flt_lo are both 1 (illegal input), flt_hi SHALL win.
REQ-028 COOL_CYCLES=0 SHALL behave as 1.
REQ-029 MAX_RETRY=0 SHALL send the first recovered trip straight to LOCKOUT.

Reset
REQ-030 With rst=1 at a clock edge: state=NORMAL, all outputs 0, retry_cnt=0, timer=0.
REQ-031 Reset SHALL override every transition, including mid-COOLDOWN and LOCKOUT.
REQ-032 The first transition after reset SHALL be evaluated on the first edge with rst=0.

Structure
REQ-033 A shared package fault_pkg SHALL hold the state enum, STATE_W=3, RETRY_W=4 and TIMER_W=16.
REQ-034 One sub-module, fs_timer, SHALL implement the 16-bit loadable down-counter with done flag, shared by cooldown and good-time.
REQ-035 Expected RTL size is 150-250 lines.

Verification (COOL_CYCLES=8, MAX_RETRY=2)
REQ-036 flt_hi pulse for 3 cycles, then flt_lo -> WARN/derate for 3 cycles, then NORMAL; trip_evt stays 0.
REQ-037 flt_hi, then flt_pers, then flt_lo -> trip_evt once, shutdown until 8 cycles of COOLDOWN end, retry_cnt=1, then NORMAL.
REQ-038 Three trip/recover cycles with no clean period -> retry_cnt goes 1 then 2; the third recovery goes to LOCKOUT; clr_req without flt_lo is ignored; clr_req with flt_lo -> NORMAL, retry_cnt=0.
REQ-039 flt_hi at COOLDOWN cycle 4 -> TRIP, trip_evt pulse, retry_cnt unchanged.
REQ-040 After a trip, 8 clean NORMAL cycles -> retry_cnt=0; a 7-cycle clean run leaves retry_cnt unchanged.
REQ-041 rst asserted during COOLDOWN and during LOCKOUT -> next edge gives all outputs 0 and state=0.
